// File: rtl/uart_mmio_driver.sv
// UART register-bus master: polls status then writes each queued Tx byte (first wr low 4 cycles after the byte is queued), and reads Rx on irq.
// Backpressure: s_ready drops while the Tx FIFO is full; an Rx byte is held on m_valid until m_ready. Rx path is built only with UART_MMIO_DRIVER_RX_EN.
module uart_mmio_driver #(
  parameter int         TX_DEPTH    = 4,
  parameter logic [2:0] STATUS_ADDR = 3'd0,
  parameter logic [2:0] RX_ADDR     = 3'd1,
  parameter logic [2:0] TX_ADDR     = 3'd2,
  parameter int         TX_BUSY_BIT = 1,
  parameter logic [2:0] IRQ_RX_ID   = 3'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [2:0] addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       irq,
  input  logic [2:0] irq_id
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, STAT_RD, STAT_CHK, TX_WR, RX_RD, GAP} state_t;

  state_t          state;
  logic            phase;
  logic            tx_busy;
  logic [7:0]      mem [TX_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            rx_req;

  assign push       = s_valid && s_ready;
  assign pop        = (state == TX_WR) && phase;
  assign count_next = count + CW'(push) - CW'(pop);

`ifdef UART_MMIO_DRIVER_RX_EN
  assign rx_req = irq && (irq_id == IRQ_RX_ID) && !m_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
    end else if ((state == RX_RD) && phase) begin
      m_valid <= 1'b1;
      m_data  <= bus_rdata;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end
`else
  assign rx_req  = 1'b0;
  assign m_valid = 1'b0;
  assign m_data  = 8'h00;

  logic unused_rx;
  assign unused_rx = &{1'b0, irq, irq_id, m_ready, bus_rdata, IRQ_RX_ID};
`endif

  // s_ready is registered from the next occupancy so it falls right after the filling push.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next;
      s_ready <= (count_next != CW'(TX_DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      tx_busy   <= 1'b0;
      cs        <= 1'b1;
      rd        <= 1'b1;
      wr        <= 1'b1;
      addr      <= 3'd0;
      bus_wdata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          phase <= 1'b0;
          if (rx_req) begin
            state <= RX_RD;
            cs    <= 1'b0;
            rd    <= 1'b0;
            addr  <= RX_ADDR;
          end else if (count != '0) begin
            state <= STAT_RD;
            cs    <= 1'b0;
            rd    <= 1'b0;
            addr  <= STATUS_ADDR;
          end
        end
        STAT_RD: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase   <= 1'b0;
            tx_busy <= bus_rdata[TX_BUSY_BIT];
            cs      <= 1'b1;
            rd      <= 1'b1;
            state   <= STAT_CHK;
          end
        end
        STAT_CHK: begin
          // A busy transmitter leaves the byte queued; it is re-polled after GAP.
          if (tx_busy) begin
            state <= GAP;
          end else begin
            state     <= TX_WR;
            cs        <= 1'b0;
            wr        <= 1'b0;
            addr      <= TX_ADDR;
            bus_wdata <= mem[rd_ptr];
          end
        end
        TX_WR: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            cs    <= 1'b1;
            wr    <= 1'b1;
            state <= GAP;
          end
        end
        RX_RD: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            cs    <= 1'b1;
            rd    <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          phase <= 1'b0;
          cs    <= 1'b1;
          rd    <= 1'b1;
          wr    <= 1'b1;
        end
      endcase
    end
  end

endmodule
